// File: rtl/decoder_strobe_n_pkg.sv
// decoder_pkg: strobe modes, FSM states and the hold-counter width helper
// shared by the strobe decoder and its counter.
`default_nettype none

package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_PULSE   = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_LATCH   = 2'd2
  } strobe_mode_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // The counter must hold HOLD-1; sized on HOLD+1 so HOLD=1 still gets one bit.
  function automatic int hold_cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_strobe_n_hold_counter.sv
// strobe_hold_counter: loadable down-counter that parks at zero;
// flags zero so the strobe FSM knows the stretch has run out.
`default_nettype none

module strobe_hold_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         clear_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/decoder_strobe_n.sv
// decoder_strobe_n: handshaked N-to-NUM_OUT decoder driving a registered one-hot
// strobe (pulse, counted stretch or latched level) with out-of-range error pulse.
`default_nettype none

module decoder_strobe_n
  import decoder_pkg::*;
#(
  parameter int           N       = 3,
  parameter int           NUM_OUT = 2 ** N,
  parameter strobe_mode_t MODE    = MODE_PULSE,
  parameter int           HOLD    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       code,
  input  logic               enabler,
  input  logic               clear,
  output logic [NUM_OUT-1:0] o,
  output logic               o_valid,
  output logic               busy,
  output logic               err
);

  localparam int           CW        = hold_cnt_width(HOLD);
  localparam logic [N:0]   NUM_OUT_C = (N + 1)'(NUM_OUT);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);

  if (NUM_OUT < 1 || NUM_OUT > 2 ** N) begin : g_bad_num_out
    $error("decoder_strobe_n: NUM_OUT must be in 1..2**N");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("decoder_strobe_n: HOLD must be at least 1");
  end

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] o_q, o_d;
  logic               err_q, err_d;

  logic               w_accept;
  logic               w_in_range;
  logic               w_hit;
  logic               w_cnt_zero;
  logic [NUM_OUT-1:0] w_onehot;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_onehot
    assign w_onehot[i] = ({1'b0, code} == (N + 1)'(i));
  end

  assign in_ready   = !rst && (state_q == IDLE || MODE == MODE_PULSE);
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = ({1'b0, code} < NUM_OUT_C);
  assign w_hit      = w_accept && enabler && w_in_range;

  // Only the stretch mode needs a counter; other modes never see it expire.
  if (MODE == MODE_STRETCH) begin : g_stretch
    strobe_hold_counter #(
      .W (CW)
    ) u_hold (
      .clk          (clk),
      .rst          (rst),
      .load_i       (w_hit),
      .load_value_i (HOLD_LD),
      .clear_i      (clear && (state_q == ACTIVE)),
      .zero_o       (w_cnt_zero)
    );
  end else begin : g_no_stretch
    assign w_cnt_zero = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    err_d   = w_accept && enabler && !w_in_range;
    unique case (state_q)
      IDLE: begin
        if (w_hit) begin
          state_d = ACTIVE;
          o_d     = w_onehot;
        end
      end
      ACTIVE: begin
        if (MODE == MODE_PULSE) begin
          // A new hit overrides clear and keeps strobes back-to-back.
          if (w_hit) begin
            o_d = w_onehot;
          end else begin
            state_d = IDLE;
            o_d     = '0;
          end
        end else if (clear || (MODE == MODE_STRETCH && w_cnt_zero)) begin
          state_d = IDLE;
          o_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        o_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      o_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      err_q   <= err_d;
    end
  end

  assign o       = o_q;
  assign o_valid = |o_q;
  assign busy    = (MODE != MODE_PULSE) && (state_q == ACTIVE);
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_strobe_n.sv
// tb_decoder_strobe_n: directed checks of pulse, stretch, latch and
// reduced-range instances of decoder_strobe_n.
`default_nettype none

module tb_decoder_strobe_n;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] code = '0;
  logic       en = 1'b0;

  logic       vld_p = 0, clr_p = 0, rdy_p, ov_p, busy_p, err_p;
  logic [7:0] o_p;
  logic       vld_s = 0, clr_s = 0, rdy_s, ov_s, busy_s, err_s;
  logic [7:0] o_s;
  logic       vld_l = 0, clr_l = 0, rdy_l, ov_l, busy_l, err_l;
  logic [7:0] o_l;
  logic       vld_6 = 0, clr_6 = 0, rdy_6, ov_6, busy_6, err_6;
  logic [5:0] o_6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_strobe_n #(.N(3), .NUM_OUT(8), .MODE(MODE_PULSE), .HOLD(4)) u_pulse (
    .clk(clk), .rst(rst), .in_valid(vld_p), .in_ready(rdy_p), .code(code),
    .enabler(en), .clear(clr_p), .o(o_p), .o_valid(ov_p), .busy(busy_p), .err(err_p));

  decoder_strobe_n #(.N(3), .NUM_OUT(8), .MODE(MODE_STRETCH), .HOLD(4)) u_stretch (
    .clk(clk), .rst(rst), .in_valid(vld_s), .in_ready(rdy_s), .code(code),
    .enabler(en), .clear(clr_s), .o(o_s), .o_valid(ov_s), .busy(busy_s), .err(err_s));

  decoder_strobe_n #(.N(3), .NUM_OUT(8), .MODE(MODE_LATCH), .HOLD(4)) u_latch (
    .clk(clk), .rst(rst), .in_valid(vld_l), .in_ready(rdy_l), .code(code),
    .enabler(en), .clear(clr_l), .o(o_l), .o_valid(ov_l), .busy(busy_l), .err(err_l));

  decoder_strobe_n #(.N(3), .NUM_OUT(6), .MODE(MODE_PULSE), .HOLD(4)) u_six (
    .clk(clk), .rst(rst), .in_valid(vld_6), .in_ready(rdy_6), .code(code),
    .enabler(en), .clear(clr_6), .o(o_6), .o_valid(ov_6), .busy(busy_6), .err(err_6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_rdy_p", 32'(rdy_p), 0);
    chk("rst_rdy_s", 32'(rdy_s), 0);
    chk("rst_o_p", 32'(o_p), 0);
    chk("rst_busy_l", 32'(busy_l), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy_p", 32'(rdy_p), 1);
    chk("post_rst_rdy_s", 32'(rdy_s), 1);

    // Pulse: back-to-back code 5 then code 2
    en = 1; code = 3'd5; vld_p = 1;
    tick();
    chk("pulse_o5", 32'(o_p), 32'h20);
    chk("pulse_ov5", 32'(ov_p), 1);
    chk("pulse_rdy5", 32'(rdy_p), 1);
    chk("pulse_busy5", 32'(busy_p), 0);
    code = 3'd2;
    tick();
    chk("pulse_o2", 32'(o_p), 32'h04);
    chk("pulse_rdy2", 32'(rdy_p), 1);
    chk("pulse_busy2", 32'(busy_p), 0);
    vld_p = 0;
    tick();
    chk("pulse_idle_o", 32'(o_p), 0);
    chk("pulse_idle_ov", 32'(ov_p), 0);

    // Pulse: clear and accept together, accept wins
    code = 3'd0; vld_p = 1; clr_p = 1;
    tick();
    chk("pulse_clr_acc", 32'(o_p), 32'h01);
    vld_p = 0; clr_p = 0;
    tick();
    chk("pulse_clr_after", 32'(o_p), 0);

    // Stretch: code 3 held 4 cycles, code 6 waiting behind it
    code = 3'd3; vld_s = 1;
    tick();
    code = 3'd6;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("str_o_c%0d", i), 32'(o_s), 32'h08);
      chk($sformatf("str_rdy_c%0d", i), 32'(rdy_s), 0);
      chk($sformatf("str_busy_c%0d", i), 32'(busy_s), 1);
      tick();
    end
    chk("str_end_o", 32'(o_s), 0);
    chk("str_end_rdy", 32'(rdy_s), 1);
    chk("str_end_busy", 32'(busy_s), 0);
    tick();
    chk("str_next_o", 32'(o_s), 32'h40);
    vld_s = 0;
    tick();
    chk("str_next_hold", 32'(o_s), 32'h40);
    clr_s = 1;
    tick();
    chk("str_abort_o", 32'(o_s), 0);
    chk("str_abort_rdy", 32'(rdy_s), 1);
    clr_s = 0;

    // Latch: code 7 held 10 cycles, code 1 pending until clear
    code = 3'd7; vld_l = 1;
    tick();
    code = 3'd1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("lat_o_c%0d", i), 32'(o_l), 32'h80);
      chk($sformatf("lat_rdy_c%0d", i), 32'(rdy_l), 0);
      if (i < 9) tick();
    end
    clr_l = 1;
    tick();
    chk("lat_clr_o", 32'(o_l), 0);
    chk("lat_clr_rdy", 32'(rdy_l), 1);
    clr_l = 0;
    tick();
    chk("lat_pending_o", 32'(o_l), 32'h02);
    chk("lat_pending_busy", 32'(busy_l), 1);
    vld_l = 0; clr_l = 1;
    tick();
    clr_l = 0;
    chk("lat_clr2_o", 32'(o_l), 0);

    // NUM_OUT=6: out-of-range error, gated accept, in-range top code
    code = 3'd6; en = 1; vld_6 = 1;
    tick();
    chk("six_err6", 32'(err_6), 1);
    chk("six_o6", 32'(o_6), 0);
    code = 3'd4; en = 0;
    tick();
    chk("six_en0_err", 32'(err_6), 0);
    chk("six_en0_o", 32'(o_6), 0);
    code = 3'd5; en = 1;
    tick();
    chk("six_o5", 32'(o_6), 32'h20);
    chk("six_o5_err", 32'(err_6), 0);
    vld_6 = 0;
    tick();
    chk("six_idle_o", 32'(o_6), 0);

    // Reset in the middle of a stretch
    code = 3'd2; vld_s = 1;
    tick();
    vld_s = 0;
    chk("rst_mid_o1", 32'(o_s), 32'h04);
    tick();
    chk("rst_mid_o2", 32'(o_s), 32'h04);
    rst = 1;
    #1;
    chk("rst_mid_o", 32'(o_s), 0);
    chk("rst_mid_busy", 32'(busy_s), 0);
    chk("rst_mid_err", 32'(err_s), 0);
    chk("rst_mid_rdy", 32'(rdy_s), 0);
    tick();
    rst = 0;
    #1;
    chk("rst_rel_rdy", 32'(rdy_s), 1);
    code = 3'd1; vld_s = 1;
    tick();
    vld_s = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_fresh_o_c%0d", i), 32'(o_s), 32'h02);
      tick();
    end
    chk("rst_fresh_end", 32'(o_s), 0);
    chk("rst_fresh_rdy", 32'(rdy_s), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
